nanci_col_drain: RTL and testbench
==================================

# nanci_col_drain

Result-side counterpart of the Nanci `PE` mesh. After a sort phase completes, it snapshots the `o_PE` words of one mesh column (SQRT_N PEs) in a single cycle. It then streams them out one word per transfer over a valid/ready interface to the host-side readout logic, in row order. It is the reader of the words the PEs produce, just as the memory-file load path is their writer.

## Interface
Parameters:
- `SQRT_N`, 4: PEs per column, i.e. words per drain; must be ≥ 2.
- `ADDR_WIDTH`, 3: address field width of a PE word.
- `DATA_WIDTH`, 3: data (sort key) field width of a PE word.
- Derived: W = ADDR_WIDTH+DATA_WIDTH; IDX_W = max(1, $clog2(SQRT_N)).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `i_sort_done`  in  1  single-cycle pulse: column outputs are final.
- `i_PE_col`  in  SQRT_N*W  concatenated `o_PE` words; row j at bits [j*W +: W]; each word = {addr, data}, addr in MSBs.
- `o_word`  out  W  current output word.
- `o_index`  out  IDX_W  row index of `o_word`.
- `o_valid`  out  1  `o_word`/`o_index` valid.
- `i_ready`  in  1  consumer accepts when high together with `o_valid`.
- `o_last`  out  1  high with `o_valid` when index = SQRT_N-1.
- `o_busy`  out  1  high in STREAM.
- `o_done`  out  1  one-cycle pulse after last transfer.
- `o_sort_err`  out  1  sticky ordering error (see Configuration).

## Operation
- FSM states: IDLE, STREAM.
- IDLE: `i_sort_done`=1 → copy all SQRT_N words into an internal buffer, clear index to 0, clear `o_sort_err`, go to STREAM.
- STREAM: `o_valid`=1, `o_word`=buf[index]. Transfer = `o_valid & i_ready`. On a transfer with index < SQRT_N-1, increment index. On a transfer with index = SQRT_N-1, go to IDLE and pulse `o_done` on the next cycle.
- `i_sort_done` in STREAM is ignored, including the cycle of the final transfer. The buffer is never overwritten mid-stream.
- `i_PE_col` is sampled only on the capture edge. Later changes do not affect output.
- Output words are stable while `o_valid`=1 and `i_ready`=0. Index never wraps past SQRT_N-1.

## Timing
- Reset (rst=0 at a rising edge): state IDLE, index 0, `o_valid`/`o_last`/`o_busy`/`o_done`/`o_sort_err` = 0, `o_word` = 0. Reset during STREAM aborts the drain immediately; no `o_done` is produced.
- Latency: `i_sort_done` high at edge k → `o_valid`=1 with row 0 after edge k.
- Throughput: one word per cycle with `i_ready` held high. Total drain is SQRT_N cycles; `o_done` is high in the cycle after the last transfer and `o_valid` is 0 in that cycle.
- Earliest re-capture: the edge at which `o_done` is high, since state is already IDLE.
- All outputs are registered; no combinational path from `i_ready` to `o_valid`.

## Configuration
- `NANCI_DRAIN_CHECK_EN` defined: on each transfer with index ≥ 1, compare the data field of the transferred word against the data field of the previously transferred word, unsigned. If the current value is less than the previous one, set `o_sort_err` one edge later. The flag holds until the next capture or reset.
- Not defined: no comparator or previous-word register is built, and `o_sort_err` is tied to 0.

## Test plan
- Basic drain: SQRT_N=4, ADDR_WIDTH=DATA_WIDTH=3, col = {011101, 010011, 001010, 000001} (row3..row0), `i_ready`=1, pulse `i_sort_done` → over 4 consecutive cycles `o_word`/`o_index` = 000001/0, 001010/1, 010011/2, 011101/3. `o_last` is high only on the last of these. `o_done` pulses once, one cycle later.
- Backpressure: same data, `i_ready` low for 3 cycles at index 1 → `o_word` holds 001010 and `o_valid` stays 1; the stream resumes at index 2 with no words lost or duplicated.
- Ignored re-trigger: pulse `i_sort_done` with different col data during index 2 → the remaining output is still 010011, 011101; exactly one `o_done`.
- Reset mid-stream: rst=0 for one edge at index 1 → next cycle `o_valid`=0, `o_busy`=0, no `o_done`. A fresh `i_sort_done` then restarts from index 0.
- Sort check (macro defined): rows 0..3 data = 001, 011, 010, 101 → `o_sort_err` rises after the index-2 transfer and stays 1 until the next capture. With the macro undefined, `o_sort_err` stays 0.

Source files
------------

// File: rtl/nanci_col_drain.sv
// nanci_col_drain: snapshots one column of PE result words and streams them
// out in row order over a valid/ready handshake.
// Optional build macro: NANCI_DRAIN_CHECK_EN adds a running ascending-order
// check on the data field of the streamed words (o_sort_err).
//
// state  | meaning
// IDLE   | waiting for i_sort_done; buffer contents are stale
// STREAM | presenting col_buf_q[idx_q] until the last row is accepted
module nanci_col_drain #(
  parameter int SQRT_N     = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  localparam int W     = ADDR_WIDTH + DATA_WIDTH,
  localparam int IDX_W = (SQRT_N > 1) ? $clog2(SQRT_N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_sort_done,
  input  logic [SQRT_N*W-1:0] i_PE_col,
  output logic [W-1:0]        o_word,
  output logic [IDX_W-1:0]    o_index,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_sort_err
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SQRT_N - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     col_buf_q [SQRT_N];
  logic [W-1:0]     col_buf_d [SQRT_N];
  logic [W-1:0]     word_q, word_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] nxt_idx;
  logic             capture;
  logic             xfer;

  assign capture = (state_q == IDLE) && i_sort_done;
  assign xfer    = (state_q == STREAM) && i_ready;
  assign nxt_idx = idx_q + IDX_W'(1);

  // Next-state: capture the column in IDLE, advance one row per accepted word in STREAM.
  // The presented word is preloaded from the buffer so o_word is a plain register.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    col_buf_d = col_buf_q;
    word_d    = word_q;
    last_d    = last_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_sort_done) begin
          for (int j = 0; j < SQRT_N; j++) begin
            col_buf_d[j] = i_PE_col[j*W +: W];
          end
          idx_d   = '0;
          word_d  = i_PE_col[W-1:0];
          last_d  = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (i_ready) begin
          if (idx_q == LAST_IDX) begin
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d  = nxt_idx;
            word_d = col_buf_q[nxt_idx];
            last_d = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any drain in progress without o_done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int j = 0; j < SQRT_N; j++) begin
        col_buf_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      last_q    <= last_d;
      done_q    <= done_d;
      col_buf_q <= col_buf_d;
    end
  end

  assign o_word  = word_q;
  assign o_index = idx_q;
  assign o_valid = (state_q == STREAM);
  assign o_busy  = (state_q == STREAM);
  assign o_last  = last_q;
  assign o_done  = done_q;

`ifdef NANCI_DRAIN_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  err_q, err_d;

  // Remember the previous accepted key and flag any descending pair until next capture.
  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    if (capture) begin
      err_d = 1'b0;
    end else if (xfer) begin
      prev_d = word_q[DATA_WIDTH-1:0];
      if ((idx_q != '0) && (word_q[DATA_WIDTH-1:0] < prev_q)) begin
        err_d = 1'b1;
      end
    end
  end

  // Order-check registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign o_sort_err = err_q;
`else
  assign o_sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_nanci_col_drain.sv
// Testbench for nanci_col_drain: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based scoreboard of expected transfers.
module tb_nanci_col_drain;
  localparam int SQRT_N = 4;
  localparam int AW     = 3;
  localparam int DW     = 3;
  localparam int W      = AW + DW;
  localparam int IDX_W  = 2;
  localparam int COLW   = SQRT_N * W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_sort_done = 1'b0;
  logic [COLW-1:0]  i_PE_col = '0;
  logic             i_ready = 1'b0;
  logic [W-1:0]     o_word;
  logic [IDX_W-1:0] o_index;
  logic             o_valid, o_last, o_busy, o_done, o_sort_err;

  int checks = 0;
  int errors = 0;

  nanci_col_drain #(.SQRT_N(SQRT_N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .i_sort_done(i_sort_done), .i_PE_col(i_PE_col),
    .o_word(o_word), .o_index(o_index), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_sort_err(o_sort_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  // Words still owed to the consumer, front = currently presented.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] snap[SQRT_N];
  int  sent = 0;
  bit  exp_done = 0;
  bit  exp_err = 0;
  bit  exp_zero_word = 0;
  bit  chk_en = 0;

  // Error after k accepted words: some accepted word has a smaller key than its predecessor.
  function automatic bit err_after(input int k);
    bit e = 0;
`ifdef NANCI_DRAIN_CHECK_EN
    for (int i = 1; i < k; i++)
      if (snap[i][DW-1:0] < snap[i-1][DW-1:0]) e = 1;
`endif
    return e;
  endfunction

  always @(posedge clk) begin
    bit nd;
    nd = 0;
    if (!rst) begin
      exp_q.delete();
      sent = 0;
      exp_err = 0;
      exp_zero_word = 1;
    end else if (exp_q.size() == 0) begin
      if (i_sort_done) begin
        for (int j = 0; j < SQRT_N; j++) begin
          snap[j] = i_PE_col[j*W +: W];
          exp_q.push_back(i_PE_col[j*W +: W]);
        end
        sent = 0;
        exp_err = 0;
        exp_zero_word = 0;
      end
    end else if (i_ready) begin
      void'(exp_q.pop_front());
      sent++;
      exp_err = err_after(sent);
      if (exp_q.size() == 0) nd = 1;
    end
    exp_done = nd;
  end

  // Compare process: outputs checked mid-cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", int'(o_valid), int'(exp_q.size() > 0));
      check("busy", int'(o_busy), int'(exp_q.size() > 0));
      check("done", int'(o_done), int'(exp_done));
      check("sort_err", int'(o_sort_err), int'(exp_err));
      if (exp_q.size() > 0) begin
        check("word", int'(o_word), int'(exp_q[0]));
        check("index", int'(o_index), SQRT_N - exp_q.size());
        check("last", int'(o_last), int'(exp_q.size() == 1));
      end else begin
        check("last_idle", int'(o_last), 0);
      end
      if (exp_zero_word) check("reset_word", int'(o_word), 0);
    end
  end

  // Transfer log and done counter for the directed literal checks.
  int log_idx[$];
  int log_word[$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (rst && o_valid && i_ready) begin
      log_idx.push_back(int'(o_index));
      log_word.push_back(int'(o_word));
    end
    if (o_done) done_cnt++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_word.delete();
    done_cnt = 0;
  endtask

  task automatic check_log(input string name, input int w0, input int w1, input int w2, input int w3);
    int exp_w[4];
    exp_w = '{w0, w1, w2, w3};
    check({name, "_len"}, log_word.size(), 4);
    for (int i = 0; i < 4 && i < log_word.size(); i++) begin
      check({name, "_idx"}, log_idx[i], i);
      check({name, "_word"}, log_word[i], exp_w[i]);
    end
  endtask

  localparam logic [COLW-1:0] COL_A = {6'b011101, 6'b010011, 6'b001010, 6'b000001};
  localparam logic [COLW-1:0] COL_B = {6'b111000, 6'b110111, 6'b101110, 6'b100101};
  localparam logic [COLW-1:0] COL_S = {6'b011101, 6'b010010, 6'b001011, 6'b000001};

  initial begin
    rst = 1'b0;
    tick(2);
    chk_en = 1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_word", int'(o_word), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_err", int'(o_sort_err), 0);
    rst = 1'b1;
    tick(1);

    // Basic drain
    clear_log();
    i_PE_col = COL_A; i_ready = 1'b1; i_sort_done = 1'b1;
    tick(1);
    i_sort_done = 1'b0;
    check("basic_lat_valid", int'(o_valid), 1);
    check("basic_lat_word", int'(o_word), 6'b000001);
    tick(6);
    check_log("basic", 6'b000001, 6'b001010, 6'b010011, 6'b011101);
    check("basic_done_cnt", done_cnt, 1);

    // Backpressure at index 1
    clear_log();
    i_sort_done = 1'b1;
    tick(1);
    i_sort_done = 1'b0;
    tick(1);
    i_ready = 1'b0;
    tick(3);
    check("bp_hold_word", int'(o_word), 6'b001010);
    check("bp_hold_valid", int'(o_valid), 1);
    i_ready = 1'b1;
    tick(4);
    check_log("bp", 6'b000001, 6'b001010, 6'b010011, 6'b011101);
    check("bp_done_cnt", done_cnt, 1);

    // Re-trigger during index 2 is ignored
    clear_log();
    i_sort_done = 1'b1;
    tick(1);
    i_sort_done = 1'b0;
    tick(2);
    i_PE_col = COL_B; i_sort_done = 1'b1;
    tick(1);
    i_sort_done = 1'b0;
    tick(3);
    check_log("retrig", 6'b000001, 6'b001010, 6'b010011, 6'b011101);
    check("retrig_done_cnt", done_cnt, 1);

    // Reset mid-stream at index 1, then a fresh drain
    i_PE_col = COL_A;
    clear_log();
    i_sort_done = 1'b1;
    tick(1);
    i_sort_done = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_busy", int'(o_busy), 0);
    tick(3);
    check("midrst_done_cnt", done_cnt, 0);
    clear_log();
    i_sort_done = 1'b1;
    tick(1);
    i_sort_done = 1'b0;
    tick(5);
    check_log("restart", 6'b000001, 6'b001010, 6'b010011, 6'b011101);

    // Sort check: keys 001, 011, 010, 101
    i_PE_col = COL_S;
    i_sort_done = 1'b1;
    tick(1);
    i_sort_done = 1'b0;
    tick(2);
    check("sort_pre", int'(o_sort_err), 0);
    tick(1);
`ifdef NANCI_DRAIN_CHECK_EN
    check("sort_rise", int'(o_sort_err), 1);
    tick(3);
    check("sort_sticky", int'(o_sort_err), 1);
`else
    check("sort_off", int'(o_sort_err), 0);
    tick(3);
    check("sort_off_end", int'(o_sort_err), 0);
`endif
    i_PE_col = COL_A;
    i_sort_done = 1'b1;
    tick(1);
    i_sort_done = 1'b0;
    check("sort_clear", int'(o_sort_err), 0);
    tick(5);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 59) != 0);
      i_ready     = ($urandom_range(0, 3) != 0);
      i_sort_done = ($urandom_range(0, 4) == 0);
      i_PE_col    = COLW'($urandom);
      tick(1);
    end
    rst = 1'b1; i_sort_done = 1'b0; i_ready = 1'b1;
    tick(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
